uart_mmio: RTL and testbench



---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_mmio_if.sv | 11 +
 rtl/uart_rx_fifo.sv | 47 ++++
 rtl/uart_mmio.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, CON bit positions, FSM state encodings and
// RX FIFO depth shared by the uart_mmio slice.
package uart_pkg;

  localparam logic [7:0] ADDR_TXD = 8'h18;
  localparam logic [7:0] ADDR_RXD = 8'h1C;
  localparam logic [7:0] ADDR_CON = 8'h20;

  localparam int CON_TXIE   = 0;
  localparam int CON_RXIE   = 1;
  localparam int CON_TXDONE = 2;
  localparam int CON_RXV    = 3;
  localparam int CON_TXBUSY = 4;
  localparam int CON_FERR   = 5;
  localparam int CON_OVR    = 6;
  localparam int CON_TXERR  = 7;

  localparam int RX_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    TXS_IDLE  = 2'd0,
    TXS_START = 2'd1,
    TXS_DATA  = 2'd2,
    TXS_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RXS_IDLE  = 2'd0,
    RXS_START = 2'd1,
    RXS_DATA  = 2'd2,
    RXS_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_mmio_if.sv
// uart_mmio_if: MEM-stage data bus between the CPU (master) and the UART (slave).
interface uart_mmio_if;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output mem_rd, output mem_wr, output addr, output wdata, input rdata);
  modport slave  (input mem_rd, input mem_wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small RX byte FIFO. A push while full is accepted only when a
// pop happens in the same cycle (pop first, then store).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART on the MEM-stage bus (TXD 0x18, RXD 0x1C,
// CON 0x20) with level irq. Define UART_RX_FIFO_EN to replace the single RX
// holding register with a 4-entry FIFO.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       reset,
  uart_mmio_if.slave bus,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       irq
);
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [1:0]  TX_IDLE   = TXS_IDLE;
  localparam logic [1:0]  TX_START  = TXS_START;
  localparam logic [1:0]  TX_DATA   = TXS_DATA;
  localparam logic [1:0]  TX_STOP   = TXS_STOP;
  localparam logic [1:0]  RX_IDLE   = RXS_IDLE;
  localparam logic [1:0]  RX_START  = RXS_START;
  localparam logic [1:0]  RX_DATA   = RXS_DATA;
  localparam logic [1:0]  RX_STOP   = RXS_STOP;

  logic        sel_txd, sel_rxd, sel_con, rd_eff, wr_txd, wr_con, con_rd, rx_pop;
  logic [1:0]  tx_state;
  logic        tx_pend, tx_busy, tx_load, tx_done_set, txerr_set;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        rx_s1, rx_s2;
  logic [1:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift, rx_byte;
  logic        rx_deliver, ferr_set, ovr_set, rxv;
  logic        txie, rxie, txdone, ferr, ovr, txerr;
  logic [7:0]  con_val;
  logic        unused_bits;

  // A simultaneous write suppresses every read side-effect
  assign sel_txd   = (bus.addr[7:0] == ADDR_TXD);
  assign sel_rxd   = (bus.addr[7:0] == ADDR_RXD);
  assign sel_con   = (bus.addr[7:0] == ADDR_CON);
  assign rd_eff    = bus.mem_rd & ~bus.mem_wr;
  assign wr_txd    = bus.mem_wr & sel_txd;
  assign wr_con    = bus.mem_wr & sel_con;
  assign con_rd    = rd_eff & sel_con;
  assign rx_pop    = rd_eff & sel_rxd & rxv;
  assign unused_bits = ^{bus.addr[31:8], bus.wdata[31:8]};

  // A pending write counts as busy so a second write in that window is rejected
  assign tx_busy     = tx_pend | (tx_state != TX_IDLE);
  assign tx_load     = wr_txd & ~tx_busy;
  assign txerr_set   = wr_txd & tx_busy;
  assign tx_done_set = (tx_state == TX_STOP) && (tx_cnt == BAUD_LAST);

  // TX sequencing: write edge arms tx_pend, next edge starts the start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_pend  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pend) begin
            tx_pend  <= 1'b0;
            tx_state <= TX_START;
            tx_cnt   <= '0;
            uart_tx  <= 1'b0;
          end else if (tx_load) begin
            tx_pend <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
            uart_tx  <= tx_shift[0];
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        TX_DATA: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit  <= tx_bit + 3'd1;
              uart_tx <= tx_shift[1];
            end
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        default: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else tx_cnt <= tx_cnt + 16'd1;
        end
      endcase
    end
  end

  // TX data byte: captured on an accepted write, shifted right per data bit
  always_ff @(posedge clk) begin
    if (tx_load) tx_shift <= bus.wdata[7:0];
    else if (tx_state == TX_DATA && tx_cnt == BAUD_LAST) tx_shift <= {1'b0, tx_shift[7:1]};
  end

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
    end
  end

  // RX sequencing: half-bit to centre of start bit, then one sample per bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        RX_DATA: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt <= '0;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        default: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
      endcase
    end
  end

  // RX data byte assembled LSB first
  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_cnt == BAUD_LAST) rx_shift <= {rx_s2, rx_shift[7:1]};
  end

  assign rx_deliver = (rx_state == RX_STOP) && (rx_cnt == BAUD_LAST) && rx_s2;
  assign ferr_set   = (rx_state == RX_STOP) && (rx_cnt == BAUD_LAST) && !rx_s2;

`ifdef UART_RX_FIFO_EN
  logic fifo_full, fifo_empty;

  uart_rx_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_deliver),
    .pop   (rx_pop),
    .din   (rx_shift),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (rx_byte)
  );

  assign rxv     = ~fifo_empty;
  assign ovr_set = rx_deliver & fifo_full & ~rx_pop;
`else
  logic       rx_full;
  logic [7:0] rx_buf;

  // Holding-register valid: a pop and a delivery in one cycle leave it full
  always_ff @(posedge clk) begin
    if (reset) rx_full <= 1'b0;
    else if (rx_deliver) rx_full <= 1'b1;
    else if (rx_pop) rx_full <= 1'b0;
  end

  // Holding-register data: a delivery onto an unpopped full buffer is dropped
  always_ff @(posedge clk) begin
    if (rx_deliver && (!rx_full || rx_pop)) rx_buf <= rx_shift;
  end

  assign rxv     = rx_full;
  assign rx_byte = rx_buf;
  assign ovr_set = rx_deliver & rx_full & ~rx_pop;
`endif

  // CON enables and sticky flags; a set in the same cycle as a CON read wins
  always_ff @(posedge clk) begin
    if (reset) begin
      txie   <= 1'b0;
      rxie   <= 1'b0;
      txdone <= 1'b0;
      ferr   <= 1'b0;
      ovr    <= 1'b0;
      txerr  <= 1'b0;
    end else begin
      if (wr_con) begin
        txie <= bus.wdata[CON_TXIE];
        rxie <= bus.wdata[CON_RXIE];
      end
      if (con_rd) begin
        txdone <= 1'b0;
        ferr   <= 1'b0;
        ovr    <= 1'b0;
        txerr  <= 1'b0;
      end
      if (tx_done_set) txdone <= 1'b1;
      if (ferr_set)    ferr   <= 1'b1;
      if (ovr_set)     ovr    <= 1'b1;
      if (txerr_set)   txerr  <= 1'b1;
    end
  end

  assign con_val = {txerr, ovr, ferr, tx_busy, rxv, txdone, rxie, txie};
  assign irq     = (txie & txdone) | (rxie & rxv);

  // Zero-wait read mux for the MEM/WB register
  always_comb begin
    bus.rdata = '0;
    if (bus.mem_rd) begin
      if (sel_rxd && rxv) bus.rdata = {24'b0, rx_byte};
      else if (sel_con)   bus.rdata = {24'b0, con_val};
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for uart_mmio at BAUD_DIV=16. Stimulus pushes
// expected read data / line levels into queues; a negedge monitor pops and
// compares whenever a read or a probe is presented.
module tb_uart_mmio;
  localparam int BD = 16;

  typedef struct {
    string       name;
    logic [31:0] exp;
    int          kind;
  } chk_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx, irq;
  logic probe_req = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wedge;
  chk_t rd_q[$];
  chk_t pr_q[$];

  uart_mmio_if bus();

  uart_mmio #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .irq     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares read data and probed line levels against queued expectations
  always @(negedge clk) begin
    chk_t e;
    logic [31:0] act;
    if (bus.mem_rd) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: got 0x%08h required nothing", bus.rdata);
      end else begin
        e = rd_q.pop_front();
        if (bus.rdata !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%08h required 0x%08h", e.name, bus.rdata, e.exp);
        end
      end
    end
    if (probe_req) begin
      n_cmp++;
      if (pr_q.size() == 0) begin
        n_bad++;
        $display("FAIL probe_unexpected: empty queue");
      end else begin
        e = pr_q.pop_front();
        act = (e.kind == 0) ? {31'b0, uart_tx} : {31'b0, irq};
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %0d required %0d", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus.addr = {24'b0, a};
    bus.wdata = d;
    bus.mem_wr = 1'b1;
    tick();
    bus.mem_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
    rd_q.push_back('{nm, exp, 0});
    bus.addr = {24'b0, a};
    bus.mem_rd = 1'b1;
    tick();
    bus.mem_rd = 1'b0;
  endtask

  task automatic probe(input int kind, input logic exp, input string nm);
    pr_q.push_back('{nm, {31'b0, exp}, kind});
    probe_req = 1'b1;
    tick();
    probe_req = 1'b0;
  endtask

  // Probe mid-bit of each of the 10 frame bits; the write edge is wedge
  task automatic check_tx_frame(input logic [7:0] b, input int we, input string nm);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      wait_until(we + 9 + BD * i);
      probe(0, f[i], $sformatf("%s_bit%0d", nm, i));
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (BD) tick();
    end
    uart_rx = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    probe(0, 1'b1, "rst_uart_tx");
    probe(1, 1'b0, "rst_irq");
    bus_read(8'h20, 32'h00, "rst_con");
    bus_read(8'h1C, 32'h00, "rst_rxd");

    // TX 0xA5: bit timing, TXDONE at write edge + 161, read-to-clear
    bus_write(8'h18, 32'hA5);
    wedge = cyc;
    check_tx_frame(8'hA5, wedge, "txa5");
    wait_until(wedge + 160);
    bus_read(8'h20, 32'h10, "txa5_con_busy_last");
    bus_read(8'h20, 32'h04, "txa5_con_done");
    bus_read(8'h20, 32'h00, "txa5_con_cleared");
    bus_read(8'h18, 32'h00, "txd_read_zero");

    // RX 0x3C with RXIE: irq, RXD pop, irq drops
    bus_write(8'h20, 32'h02);
    send_rx(8'h3C, 1'b1);
    probe(1, 1'b1, "rx3c_irq_set");
    bus_read(8'h20, 32'h0A, "rx3c_con");
    bus_read(8'h1C, 32'h3C, "rx3c_rxd");
    probe(1, 1'b0, "rx3c_irq_clear");
    bus_read(8'h1C, 32'h00, "rx3c_rxd_empty");
    bus_write(8'h20, 32'h00);

    // Framing error
    send_rx(8'h55, 1'b0);
    bus_read(8'h20, 32'h20, "ferr_con");
    bus_read(8'h20, 32'h00, "ferr_cleared");

    // Overrun
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) begin
      send_rx(8'(i), 1'b1);
      repeat (4) tick();
    end
    bus_read(8'h20, 32'h48, "ovr_con");
    for (int i = 1; i <= 4; i++) bus_read(8'h1C, 32'(i), $sformatf("fifo_rxd%0d", i));
    bus_read(8'h1C, 32'h00, "fifo_rxd_empty");
`else
    send_rx(8'h81, 1'b1);
    repeat (4) tick();
    send_rx(8'h42, 1'b1);
    bus_read(8'h20, 32'h48, "ovr_con");
    bus_read(8'h1C, 32'h81, "ovr_rxd_first");
    bus_read(8'h1C, 32'h00, "ovr_rxd_empty");
`endif
    bus_read(8'h20, 32'h00, "ovr_cleared");

    // TXD write while busy: frame unchanged, TXERR, second byte never sent
    bus_write(8'h18, 32'h5A);
    wedge = cyc;
    wait_until(wedge + 3);
    bus_write(8'h18, 32'h11);
    check_tx_frame(8'h5A, wedge, "tx5a");
    wait_until(wedge + 160);
    bus_read(8'h20, 32'h90, "txerr_con");
    bus_read(8'h20, 32'h04, "txerr_con_done");
    for (int i = 0; i < 4; i++) begin
      wait_until(wedge + 170 + 40 * i);
      probe(0, 1'b1, $sformatf("txerr_idle%0d", i));
    end

    // Reset mid-frame, then a clean frame
    bus_write(8'h18, 32'hF0);
    wedge = cyc;
    wait_until(wedge + 30);
    probe(0, 1'b0, "rstmid_tx_low");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    probe(0, 1'b1, "rstmid_tx_high");
    bus_read(8'h20, 32'h00, "rstmid_con");
    bus_write(8'h18, 32'h3C);
    wedge = cyc;
    check_tx_frame(8'h3C, wedge, "tx3c");
    wait_until(wedge + 160);
    bus_read(8'h20, 32'h10, "tx3c_con_busy");
    bus_read(8'h20, 32'h04, "tx3c_con_done");

    tick();
    n_cmp++;
    if (rd_q.size() + pr_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending required 0", rd_q.size() + pr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
